mdu_ctrl: RTL
=============

# mdu_ctrl

Multi-cycle multiply/divide sequencer for the EX stage of the five-stage MIPS pipeline. It decodes the EX-stage instruction, latches operands, runs a fixed-latency cycle counter while the MDU is busy, and commits results into the HI/LO registers. It also forwards HI/LO to the EX result mux for mfhi/mflo, and raises a stall request to the hazard unit whenever the instruction in D needs the MDU while it is occupied.

## Interface
Parameters:
- MULT_CYCLES, 5, busy duration for mult/multu (1..15)
- DIV_CYCLES, 10, busy duration for div/divu (1..15)

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset; single clock domain
- instr_D  in  32  instruction in the decode stage (stall check only)
- instr_E  in  32  instruction in the execute stage
- rs_E  in  32  forwarded rs value in E
- rt_E  in  32  forwarded rt value in E
- start  out  1  combinational; high when instr_E is mult/multu/div/divu and the unit is idle
- busy  out  1  registered; high while an operation is in flight
- stall_md  out  1  combinational stall request to the hazard unit
- hi  out  32  HI register
- lo  out  32  LO register
- md_out  out  32  combinational; hi when instr_E is mfhi, else lo

## Operation
- Decode: op 000000 with funct mult 011000, multu 011001, div 011010, divu 011011, mfhi 010000, mthi 010001, mflo 010010, mtlo 010011. Any other instruction is a non-MDU instruction.
- md_D is high when instr_D is any of the 8 MDU instructions.
- State is IDLE (busy=0) or RUN (busy=1). There is a 4-bit down counter cnt.
- IDLE with start=1: the next edge latches rs_E/rt_E into op_a/op_b, latches the operation kind, loads cnt with MULT_CYCLES or DIV_CYCLES, and sets busy.
- RUN: cnt decrements on each edge. On the edge where cnt==1, the unit writes HI/LO, clears busy, and sets cnt to 0.
- Results:
  - mult: {hi,lo} = signed op_a × signed op_b, 64-bit.
  - multu: the same product, unsigned.
  - div: lo = signed quotient, hi = signed remainder. Truncate toward zero; the remainder takes the sign of the dividend.
  - divu: the unsigned equivalents.
- Division by zero: the full DIV_CYCLES latency still elapses and busy behaves normally, but HI/LO stay unchanged.
- mthi/mtlo in E while IDLE: the next edge writes rs_E into hi or lo.
- Any MDU instruction in E while busy=1 is ignored (no start, no write). The pipeline prevents this case; the block must still tolerate it.
- stall_md = md_D & (start | busy).
- Reset (asynchronous, reset==0): hi=0, lo=0, busy=0, cnt=0, operand latches cleared. Reset during RUN aborts the operation, and no HI/LO write occurs.

## Timing
- Operation latency: start is high in cycle T, so busy is high in cycles T+1 .. T+N (N = MULT_CYCLES or DIV_CYCLES).
- New hi/lo values are visible in cycle T+N+1, the first cycle with busy=0.
- mthi/mtlo: the new value is visible one cycle after the instruction is in E.
- md_out is purely combinational from the current hi/lo. mfhi in cycle T+N+1 returns the new result.
- stall_md holds for the start cycle plus the N busy cycles whenever md_D=1, so an MDU instruction in D leaves D at cycle T+N+1 at the earliest.
- Non-MDU instructions are never stalled by this block.
- Operands are sampled only on the start edge. Later changes on rs_E/rt_E do not affect the result.

## Test plan
- Signed multiply: mult with rs=0xFFFFFFFE (−2), rt=3 → busy high for exactly 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA.
- Unsigned multiply and divide: multu 0xFFFFFFFF×2 → hi=0x00000001, lo=0xFFFFFFFE. divu 100/7 → busy 10 cycles; lo=14, hi=2.
- Signed divide and divide-by-zero: div −7/2 → lo=0xFFFFFFFD (−3), hi=0xFFFFFFFF (−1). div 5/0 → busy 10 cycles; hi/lo unchanged.
- Stall window: hold mfhi in D while mult starts in E → stall_md=1 for 6 consecutive cycles, then 0. With addu in D under the same condition → stall_md=0 throughout.
- Move-to / move-from: mthi rs=0x12345678 while idle → hi=0x12345678 next cycle. mflo in E → md_out equals lo. Issue mtlo while busy → lo unaffected.
- Reset mid-operation: assert reset 3 cycles into a div → busy, hi and lo drop to 0 immediately (asynchronously). After release, the unit is idle with no late write.

Source files
------------

// File: rtl/mdu_ctrl.sv
// Multi-cycle multiply/divide sequencer for the EX stage: decodes MDU instructions,
// runs a fixed-latency busy window, commits HI/LO and raises the D-stage stall.
module mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr_D,
    input  logic [31:0] instr_E,
    input  logic [31:0] rs_E,
    input  logic [31:0] rt_E,
    output logic        start,
    output logic        busy,
    output logic        stall_md,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic [31:0] md_out
);

    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MTHI  = 6'b010001;
    localparam logic [5:0] F_MFLO  = 6'b010010;
    localparam logic [5:0] F_MTLO  = 6'b010011;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;

    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES);
    localparam logic [3:0] DIV_LOAD  = 4'(DIV_CYCLES);

    typedef enum logic [1:0] {K_MULT, K_MULTU, K_DIV, K_DIVU} kind_t;
    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t             state, state_nxt;
    logic [3:0]         cnt, cnt_nxt;
    kind_t              kind;
    logic signed [31:0] op_a, op_b;

    logic               special_E, special_D;
    logic [5:0]         funct_E, funct_D;
    logic               md_D, muldiv_E, mthi_E, mtlo_E, mfhi_E;
    logic               done;
    logic               res_we;
    logic [31:0]        res_hi, res_lo;
    logic               unused_bits;

    function automatic logic [63:0] mul_s(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [63:0] p;
        p = 64'(a) * 64'(b);
        return p;
    endfunction

    function automatic logic [63:0] mul_u(input logic [31:0] a, input logic [31:0] b);
        return 64'(a) * 64'(b);
    endfunction

    // {remainder, quotient}; SV signed / and % truncate toward zero, remainder follows dividend
    function automatic logic [63:0] div_s(input logic signed [31:0] a, input logic signed [31:0] b);
        logic signed [31:0] q, r;
        q = a / b;
        r = a % b;
        return {r, q};
    endfunction

    function automatic logic [63:0] div_u(input logic [31:0] a, input logic [31:0] b);
        return {a % b, a / b};
    endfunction

    // Decode
    assign special_E = (instr_E[31:26] == 6'b000000);
    assign special_D = (instr_D[31:26] == 6'b000000);
    assign funct_E   = instr_E[5:0];
    assign funct_D   = instr_D[5:0];

    assign md_D = special_D &&
                  (funct_D inside {F_MFHI, F_MTHI, F_MFLO, F_MTLO,
                                   F_MULT, F_MULTU, F_DIV, F_DIVU});

    assign muldiv_E = special_E && (funct_E inside {F_MULT, F_MULTU, F_DIV, F_DIVU});
    assign mthi_E   = special_E && (funct_E == F_MTHI);
    assign mtlo_E   = special_E && (funct_E == F_MTLO);
    assign mfhi_E   = special_E && (funct_E == F_MFHI);

    assign unused_bits = ^{instr_D[25:6], instr_E[25:6]};

    // FSM: state register and busy counter
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            cnt   <= 4'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            S_IDLE: begin
                if (muldiv_E) begin
                    state_nxt = S_RUN;
                    cnt_nxt   = funct_E[1] ? DIV_LOAD : MULT_LOAD;
                end
            end
            S_RUN: begin
                if (cnt == 4'd1) begin
                    state_nxt = S_IDLE;
                    cnt_nxt   = 4'd0;
                end else begin
                    cnt_nxt = cnt - 4'd1;
                end
            end
            default: begin
                state_nxt = S_IDLE;
                cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_comb begin
        start = 1'b0;
        busy  = 1'b0;
        done  = 1'b0;
        case (state)
            S_IDLE:  start = muldiv_E;
            S_RUN: begin
                busy = 1'b1;
                done = (cnt == 4'd1);
            end
            default: begin
                start = 1'b0;
                busy  = 1'b0;
            end
        endcase
    end

    assign stall_md = md_D & (start | busy);
    assign md_out   = mfhi_E ? hi : lo;

    // Result formation from the latched operands; a zero divisor suppresses the write
    always_comb begin
        logic [63:0] r;
        r      = 64'd0;
        res_we = 1'b1;
        case (kind)
            K_MULT:  r = mul_s(op_a, op_b);
            K_MULTU: r = mul_u(op_a, op_b);
            K_DIV: begin
                res_we = (op_b != 32'sd0);
                if (res_we) r = div_s(op_a, op_b);
            end
            K_DIVU: begin
                res_we = (op_b != 32'sd0);
                if (res_we) r = div_u(op_a, op_b);
            end
            default: r = 64'd0;
        endcase
        res_hi = r[63:32];
        res_lo = r[31:0];
    end

    // Operand latch and HI/LO commit
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            op_a <= 32'sd0;
            op_b <= 32'sd0;
            kind <= K_MULT;
            hi   <= 32'd0;
            lo   <= 32'd0;
        end else begin
            if (start) begin
                op_a <= rs_E;
                op_b <= rt_E;
                kind <= kind_t'(funct_E[1:0]);
            end
            if (done && res_we) begin
                hi <= res_hi;
                lo <= res_lo;
            end else if (!busy && mthi_E) begin
                hi <= rs_E;
            end else if (!busy && mtlo_E) begin
                lo <= rs_E;
            end
        end
    end

endmodule
